matmul_scheduler: RTL and testbench
===================================

MATMUL_SCHEDULER -- requirements
Module: matmul_scheduler

Interface
REQ-001 SHALL have parameter DIM, default 32, matrix dimension (rows and columns of the loader matrices).
REQ-002 SHALL have parameter READ_LAT, default 2, cycles from a row/col index change to valid loader data.
REQ-003 SHALL have parameter ACC_W, default 21, dot-product result width (32 x 8b*8b unsigned products).
REQ-004 SHALL use one clock; reset is asynchronous and active-low: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: pulse requesting one full multiply.
REQ-006 SHALL have port load_complete, input, 1 bit: loader has both matrices stored.
REQ-007 SHALL have port requested_a_row, output, $clog2(DIM) bits: A row index driven to the loader.
REQ-008 SHALL have port requested_b_col, output, $clog2(DIM) bits: B column index driven to the loader.
REQ-009 SHALL have port dot_start, output, 1 bit: one-cycle pulse telling the dot engine that the loader row/col data are valid.
REQ-010 SHALL have port dot_valid, input, 1 bit, and port dot_sum, input, ACC_W bits: dot-engine result handshake.
REQ-011 SHALL have port c_we, output, 1 bit; port c_addr, output, 2*$clog2(DIM) bits; and port c_data, output, ACC_W bits: result-buffer write port.
REQ-012 SHALL have port busy, output, 1 bit; port done, output, 1 bit; and port cycle_count, output, 32 bits.

Function
REQ-013 SHALL implement states IDLE, WAIT_LOAD, ISSUE, WAIT_RD, FIRE, WAIT_DOT, WRITE, DONE.
REQ-014 SHALL move IDLE->WAIT_LOAD on start; start outside IDLE/DONE SHALL be ignored.
REQ-015 SHALL move WAIT_LOAD->ISSUE in the first cycle load_complete=1; if load_complete is already 1 when start arrives, it SHALL pass through WAIT_LOAD in one cycle.
REQ-016 SHALL drive the current (row,col) in ISSUE, hold it stable until WRITE completes, then go to WAIT_RD.
REQ-017 SHALL stay in WAIT_RD exactly READ_LAT cycles, then go to FIRE; with READ_LAT=0 it SHALL go straight to FIRE.
REQ-018 SHALL assert dot_start for exactly one cycle in FIRE, then go to WAIT_DOT.
REQ-019 SHALL wait in WAIT_DOT indefinitely for dot_valid; dot_valid in any other state SHALL be ignored.
REQ-020 SHALL, in the WRITE state, assert c_we for one cycle with c_addr={row,col} and c_data=dot_sum captured on the dot_valid cycle.
REQ-021 SHALL use row-major order: col increments first; at col=DIM-1 it wraps to 0 and row increments; WRITE of (DIM-1,DIM-1) SHALL go to DONE, otherwise to ISSUE.
REQ-022 SHALL pulse done for one cycle on entry to DONE, then return to IDLE; start in that DONE cycle SHALL be accepted.
REQ-023 SHALL hold busy=1 in every state except IDLE.
REQ-024 SHALL handle load_complete falling mid-operation with no effect; the sequence SHALL continue.

Reset
REQ-025 SHALL, while rst_n=0, force: state IDLE; row=0, col=0; dot_start=0; c_we=0; c_addr=0; c_data=0; busy=0; done=0; cycle_count=0.
REQ-026 SHALL abandon any operation on reset mid-operation; the result buffer SHALL receive no further writes until the next start.

Configuration
REQ-027 SHALL, with MATMUL_SCHED_PERF_EN defined, count clk cycles in cycle_count while busy=1, clear it on accepted start, and hold it after done.
REQ-028 SHALL, without MATMUL_SCHED_PERF_EN, keep the cycle_count port and tie it to constant 0.

Structure
REQ-029 SHALL take DIM default, IDX_W, ELEM_W=8, ACC_W default and the state enum from the shared package matmul_pkg.
REQ-030 SHALL place the row/col counter with wrap and last flag in sub-module matmul_idx_counter.

Verification
REQ-031 SHALL cover: start with load_complete=1, dot engine answering dot_valid 3 cycles after dot_start with dot_sum=row==col ? 1 : 0 -> 1024 c_we pulses, addr 0..1023 in order, c_data=1 exactly at addr 0,33,...,1023, done once.
REQ-032 SHALL cover: start while load_complete=0, load_complete raised 50 cycles later -> requested indices first change from 0 after load_complete; no dot_start before it.
REQ-033 SHALL cover: READ_LAT=2 -> dot_start exactly 3 cycles after each index change (1 ISSUE + 2 WAIT_RD); stray dot_valid in WAIT_RD -> no c_we.
REQ-034 SHALL cover: rst_n low at c_addr=500 -> all outputs 0 asynchronously; new start restarts at addr 0.
REQ-035 SHALL cover: second start while busy -> ignored, exactly 1024 writes; start in the done cycle -> new run begins.
REQ-036 SHALL cover: MATMUL_SCHED_PERF_EN with fixed dot latency L -> cycle_count equals the analytically computed total; without the macro -> cycle_count=0 throughout.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply scheduler slice: default
// geometry, element/accumulator widths and the scheduler state encoding.
package matmul_pkg;

    localparam int DIM_DEFAULT      = 32;
    localparam int IDX_W            = $clog2(DIM_DEFAULT);
    localparam int ELEM_W           = 8;
    // Sum of DIM products of two ELEM_W-bit unsigned values.
    localparam int ACC_W_DEFAULT    = 2 * ELEM_W + IDX_W;
    localparam int READ_LAT_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOAD,
        ISSUE,
        WAIT_RD,
        FIRE,
        WAIT_DOT,
        WRITE,
        DONE
    } sched_state_t;

    // A new multiply may only be accepted from a quiescent or finishing state.
    function automatic logic accepts_start(input sched_state_t s);
        return (s == IDLE) || (s == DONE);
    endfunction

endpackage

// File: rtl/matmul_idx_counter.sv
// Row-major (row, col) walker over a DIM x DIM matrix. col advances first;
// at col = DIM-1 it wraps to 0 and row advances. last flags the final
// element (DIM-1, DIM-1); advancing from it wraps both indices to 0.
module matmul_idx_counter
    import matmul_pkg::*;
#(
    parameter int DIM = DIM_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   inc,
    output logic [$clog2(DIM)-1:0] row,
    output logic [$clog2(DIM)-1:0] col,
    output logic                   last
);

    localparam int W = $clog2(DIM);
    localparam logic [W-1:0] IDX_MAX = W'(DIM - 1);

    logic [W-1:0] row_q, row_d;
    logic [W-1:0] col_q, col_d;

    // Next-index computation: clear wins over advance.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (inc) begin
            if (col_q == IDX_MAX) begin
                col_d = '0;
                row_d = (row_q == IDX_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Index registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    // Outputs straight from the registers; last is a pure decode.
    always_comb begin
        row  = row_q;
        col  = col_q;
        last = (row_q == IDX_MAX) && (col_q == IDX_MAX);
    end

endmodule

// File: rtl/matmul_scheduler.sv
// Sequencer for a DIM x DIM matrix multiply: walks every (row, col) of C,
// requests the A row / B column from the loader, waits the read latency,
// fires the dot engine, and writes its result into the C buffer.
// Optional macro MATMUL_SCHED_PERF_EN enables the busy-cycle counter on
// cycle_count; without it cycle_count is tied to zero.
module matmul_scheduler
    import matmul_pkg::*;
#(
    parameter int DIM      = DIM_DEFAULT,
    parameter int READ_LAT = READ_LAT_DEFAULT,
    parameter int ACC_W    = ACC_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     load_complete,
    output logic [$clog2(DIM)-1:0]   requested_a_row,
    output logic [$clog2(DIM)-1:0]   requested_b_col,
    output logic                     dot_start,
    input  logic                     dot_valid,
    input  logic [ACC_W-1:0]         dot_sum,
    output logic                     c_we,
    output logic [2*$clog2(DIM)-1:0] c_addr,
    output logic [ACC_W-1:0]         c_data,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              cycle_count
);

    localparam int W       = $clog2(DIM);
    localparam int RD_W    = $clog2(READ_LAT + 2);
    localparam int RD_LAST = (READ_LAT > 0) ? READ_LAT - 1 : 0;

    sched_state_t state_q, state_d;

    logic [RD_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [ACC_W-1:0] sum_q, sum_d;

    logic         start_acc;
    logic         idx_inc;
    logic [W-1:0] row;
    logic [W-1:0] col;
    logic         idx_last;

    assign start_acc = start && accepts_start(state_q);
    assign idx_inc   = (state_q == WRITE);

    // Index walker: restarted on every accepted start, stepped once per write.
    matmul_idx_counter #(
        .DIM (DIM)
    ) u_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_acc),
        .inc   (idx_inc),
        .row   (row),
        .col   (col),
        .last  (idx_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (start)         state_d = WAIT_LOAD;
            WAIT_LOAD: if (load_complete) state_d = ISSUE;
            ISSUE:     state_d = (READ_LAT == 0) ? FIRE : WAIT_RD;
            WAIT_RD:   if (rd_cnt_q == RD_W'(RD_LAST)) state_d = FIRE;
            FIRE:      state_d = WAIT_DOT;
            WAIT_DOT:  if (dot_valid)     state_d = WRITE;
            WRITE:     state_d = idx_last ? DONE : ISSUE;
            DONE:      state_d = start ? WAIT_LOAD : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Read-latency counter and dot-result capture.
    always_comb begin
        rd_cnt_d = (state_q == WAIT_RD) ? rd_cnt_q + 1'b1 : '0;
        sum_d    = sum_q;
        if ((state_q == WAIT_DOT) && dot_valid) begin
            sum_d = dot_sum;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            sum_q    <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            sum_q    <= sum_d;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        dot_start       = (state_q == FIRE);
        c_we            = (state_q == WRITE);
        busy            = (state_q != IDLE);
        done            = (state_q == DONE);
        requested_a_row = row;
        requested_b_col = col;
        c_addr          = {row, col};
        c_data          = sum_q;
    end

`ifdef MATMUL_SCHED_PERF_EN
    logic [31:0] cycle_count_q, cycle_count_d;

    // Busy-cycle counter: cleared by an accepted start, frozen while idle.
    always_comb begin
        cycle_count_d = cycle_count_q;
        if (start_acc) begin
            cycle_count_d = '0;
        end else if (busy) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    // Busy-cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_matmul_scheduler.sv
// Directed bench for matmul_scheduler with a behavioural dot engine and a
// write scoreboard. Honours MATMUL_SCHED_PERF_EN for the cycle_count checks.
module tb_matmul_scheduler;

    localparam int DIM      = 32;
    localparam int READ_LAT = 2;
    localparam int ACC_W    = 21;
    localparam int IW       = $clog2(DIM);
    localparam int N        = DIM * DIM;
    localparam int L        = 3;
`ifdef MATMUL_SCHED_PERF_EN
    localparam int EXP_CC   = 2 + N * (READ_LAT + L + 3);
`else
    localparam int EXP_CC   = 0;
`endif

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                load_complete;
    logic [IW-1:0]       requested_a_row;
    logic [IW-1:0]       requested_b_col;
    logic                dot_start;
    logic                dot_valid;
    logic [ACC_W-1:0]    dot_sum;
    logic                c_we;
    logic [2*IW-1:0]     c_addr;
    logic [ACC_W-1:0]    c_data;
    logic                busy;
    logic                done;
    logic [31:0]         cycle_count;

    matmul_scheduler #(
        .DIM      (DIM),
        .READ_LAT (READ_LAT),
        .ACC_W    (ACC_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .load_complete   (load_complete),
        .requested_a_row (requested_a_row),
        .requested_b_col (requested_b_col),
        .dot_start       (dot_start),
        .dot_valid       (dot_valid),
        .dot_sum         (dot_sum),
        .c_we            (c_we),
        .c_addr          (c_addr),
        .c_data          (c_data),
        .busy            (busy),
        .done            (done),
        .cycle_count     (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [2*IW-1:0]  addr;
        logic [ACC_W-1:0] data;
    } wr_t;

    wr_t         sb_q[$];
    int unsigned exp_idx         = 0;
    int          write_count     = 0;
    int          done_count      = 0;
    int          ones_count      = 0;
    int          dot_start_count = 0;
    int          since           = 0;
    bit          since_valid     = 0;
    logic [IW-1:0] prev_row = '0;
    logic [IW-1:0] prev_col = '0;

    // Dot engine: answers L cycles after dot_start with row==col, and throws
    // a stray dot_valid into the first WAIT_RD cycle after every write.
    initial begin
        int cnt;
        int stray;
        logic [ACC_W-1:0] pend;
        cnt = 0;
        stray = 0;
        pend = '0;
        dot_valid = 1'b0;
        dot_sum = '0;
        forever begin
            @(negedge clk);
            dot_valid = 1'b0;
            dot_sum = '0;
            if (!rst_n) begin
                cnt = 0;
                stray = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        dot_valid = 1'b1;
                        dot_sum = pend;
                    end
                end
                if (stray > 0) begin
                    stray--;
                    if (stray == 0) begin
                        dot_valid = 1'b1;
                        dot_sum = '1;
                    end
                end
                if (dot_start) begin
                    cnt = L;
                    pend = (requested_a_row == requested_b_col) ? ACC_W'(1) : '0;
                end
                if (c_we) stray = 2;
            end
        end
    end

    // Monitor: pushes the expected write on each dot_start, pops it on c_we.
    initial begin
        wr_t e;
        logic [IW-1:0] er;
        logic [IW-1:0] ec;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                exp_idx = 0;
                since_valid = 0;
                prev_row = requested_a_row;
                prev_col = requested_b_col;
            end else begin
                if (requested_a_row !== prev_row || requested_b_col !== prev_col) begin
                    since = 0;
                    since_valid = 1;
                end else begin
                    since++;
                end
                prev_row = requested_a_row;
                prev_col = requested_b_col;
                if (done) since_valid = 0;
                if (dot_start) begin
                    dot_start_count++;
                    if (since_valid) check("dot_start_latency", since, 3);
                    er = IW'(exp_idx / DIM);
                    ec = IW'(exp_idx % DIM);
                    check("req_row", requested_a_row, er);
                    check("req_col", requested_b_col, ec);
                    e.addr = {er, ec};
                    e.data = (er == ec) ? ACC_W'(1) : '0;
                    sb_q.push_back(e);
                    exp_idx = (exp_idx + 1) % N;
                end
                if (c_we) begin
                    write_count++;
                    if (c_data == ACC_W'(1)) ones_count++;
                    if (sb_q.size() == 0) begin
                        check("unexpected_write", sb_q.size(), 1);
                    end else begin
                        e = sb_q.pop_front();
                        check("c_addr", c_addr, e.addr);
                        check("c_data", c_data, e.data);
                    end
                end
                if (done) done_count++;
`ifndef MATMUL_SCHED_PERF_EN
                check("cycle_count_tied", cycle_count, 0);
`endif
            end
        end
    end

    task automatic wait_done(input int limit, output bit seen);
        seen = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_row"},   requested_a_row, 0);
        check({tag, "_col"},   requested_b_col, 0);
        check({tag, "_dstart"}, dot_start, 0);
        check({tag, "_we"},    c_we, 0);
        check({tag, "_addr"},  c_addr, 0);
        check({tag, "_data"},  c_data, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_cc"},    cycle_count, 0);
    endtask

    initial begin
        int base_wr;
        int base_done;
        int base_ones;
        int base_ds;
        bit seen;
        bit nz_seen;

        rst_n = 1'b1;
        start = 1'b0;
        load_complete = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Run 1: loader ready; extra start while busy; load_complete drops mid-run.
        base_wr = write_count; base_done = done_count; base_ones = ones_count;
        load_complete = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("run1_busy", busy, 1);
        check("run1_cc_cleared", cycle_count, 0);
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load_complete = 1'b0;
        wait_done(20000, seen);
        check("run1_done_seen", seen, 1);
        repeat (20) @(negedge clk);
        check("run1_writes", write_count - base_wr, N);
        check("run1_done_count", done_count - base_done, 1);
        check("run1_ones", ones_count - base_ones, DIM);
        check("run1_sb_empty", sb_q.size(), 0);
        check("run1_idle", busy, 0);
        check("run1_cycle_count", cycle_count, EXP_CC);

        // Run 2: start before the loader is ready; restart in the done cycle.
        base_wr = write_count; base_done = done_count; base_ds = dot_start_count;
        load_complete = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nz_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (requested_a_row != '0 || requested_b_col != '0) nz_seen = 1;
        end
        check("run2_no_dot_start_before_load", dot_start_count - base_ds, 0);
        check("run2_idx_held_before_load", nz_seen, 0);
        check("run2_busy_waiting", busy, 1);
        load_complete = 1'b1;
        wait_done(20000, seen);
        check("run2_done_seen", seen, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("run2_writes", write_count - base_wr, N);
        check("run2_done_count", done_count - base_done, 1);
        check("run3_start_in_done_accepted", busy, 1);
        check("run3_cc_cleared", cycle_count, 0);

        // Run 3: asynchronous reset at c_addr = 500.
        base_wr = write_count;
        seen = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (c_we && c_addr == (2*IW)'(500)) begin
                seen = 1;
                break;
            end
        end
        check("run3_addr500_seen", seen, 1);
        #1 rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        check("run3_writes_before_reset", write_count - base_wr, 501);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        base_wr = write_count;
        repeat (20) @(negedge clk);
        check("post_reset_no_writes", write_count - base_wr, 0);
        check("post_reset_idle", busy, 0);

        // Run 4: fresh start after reset restarts at address 0.
        base_wr = write_count; base_done = done_count; base_ones = ones_count;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20000, seen);
        check("run4_done_seen", seen, 1);
        repeat (20) @(negedge clk);
        check("run4_writes", write_count - base_wr, N);
        check("run4_done_count", done_count - base_done, 1);
        check("run4_ones", ones_count - base_ones, DIM);
        check("run4_sb_empty", sb_q.size(), 0);
        check("run4_cycle_count", cycle_count, EXP_CC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
